tqv_periph_bus_arbiter: RTL and testbench
=========================================

# tqv_periph_bus_arbiter

Two-master arbiter and sequencer for the TinyQV peripheral register bus (address / data_in / data_write_n / data_read_n / data_out / data_ready). It shares one peripheral, e.g. the CRC unit, between requester 0 (the SPI register bridge) and requester 1 (a local streaming feeder). It generates correctly timed write and read strobes, applies width masking to read data, and bounds reads with a timeout.

## Interface

**Parameters**
- `ADDR_W`, default 6: peripheral address width.
- `TIMEOUT`, default 255: maximum cycles a read waits for `data_ready`. Legal range 1..255.

**Ports**
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `rN_req`, in, 1 (N=0,1): request level, held until `rN_ack`.
- `rN_we`, in, 1: 1 = write, 0 = read.
- `rN_addr`, in, ADDR_W: register address.
- `rN_wdata`, in, 32: write data.
- `rN_txn`, in, 2: transfer width; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `rN_ack`, out, 1: one-cycle completion pulse.
- `r_err`, out, 1: valid with any ack; 1 = timeout or illegal txn.
- `r_rdata`, out, 32: read result, valid with ack, held until the next ack.
- `address`, out, ADDR_W: to peripheral.
- `data_in`, out, 32: to peripheral.
- `data_write_n`, out, 2: write strobe; 11 = idle.
- `data_read_n`, out, 2: read strobe; 11 = idle.
- `data_out`, in, 32: from peripheral.
- `data_ready`, in, 1: read data valid.
- `busy`, out, 1: FSM not in IDLE.
- `owner`, out, 1: index of the current or last granted requester.

## Operation

**Reset values.** Asynchronous reset forces every output to a defined value immediately:
- `address` = 0, `data_in` = 0, `r_rdata` = 0
- `data_write_n` = 11, `data_read_n` = 11
- `rN_ack` = 0, `r_err` = 0, `busy` = 0, `owner` = 1, so requester 0 wins the first tie
- FSM to IDLE, timeout counter to 0

Reset during a transfer aborts it with no ack. Strobes deassert asynchronously.

**FSM states**
- **IDLE**
  - No requests: stay in IDLE.
  - One requester: grant it.
  - Both requesters: grant the one that is not `owner` (round-robin).
  - On grant, register `owner`, `address`, `data_in` (= wdata, or 0 for reads), the txn and we.
  - Next state: WR if we=1; RD if we=0; DONE with err=1 if txn=11.
- **WR**
  - Drive `data_write_n` = txn for exactly one cycle.
  - Next state: DONE, err=0.
- **RD**
  - Drive `data_read_n` = txn every cycle in RD. The timeout counter increments each RD cycle.
  - If `data_ready`=1: capture masked `data_out` into `r_rdata`, err=0, go to DONE.
  - Otherwise, if counter = TIMEOUT-1: `r_rdata`=0, err=1, go to DONE.
- **DONE**
  - Pulse `r[owner]_ack` for one cycle with `r_err`.
  - Clear the counter and go to IDLE.
  - Requesters are not sampled in DONE. The owner must drop req on the ack edge; req still high in the next IDLE cycle is a new request.

**Read masking**
- txn 00: `r_rdata`[31:8] = 0.
- txn 01: `r_rdata`[31:16] = 0.
- txn 10: unmasked.

`data_in` is passed unmasked; the peripheral uses the strobe width.

`address` and `data_in` hold their last values outside transfers.

## Timing

- **Requests:** sampled on the edge that ends an IDLE cycle (cycle T).
- **Write:** strobe in cycle T+1, ack in T+2. Back-to-back writes from one requester complete every 3 cycles.
- **Read:** strobe from T+1. If `data_ready` arrives in cycle R (R ≥ T+1), ack and data appear in R+1. Same-cycle ready (R = T+1) gives ack in T+2.
- **Timeout:** strobe held for exactly TIMEOUT cycles (T+1 .. T+TIMEOUT); ack with err=1 in T+TIMEOUT+1.
- **Illegal txn:** no strobe; ack with err=1 in T+1.
- **Stray ready:** `data_ready` outside RD is ignored.
- **Requester changes:** changes to req, addr or data after grant have no effect on the current transfer.
- **Fairness:** with both requesters continuously requesting, grants alternate 0,1,0,1.

## Test plan

1. **Reset, then write from requester 0.** After reset release, r0 writes addr 0x05, wdata 0xDEADBEEF, txn 10. Expected: `data_write_n`=10 for exactly one cycle with `address`=0x05 and `data_in`=0xDEADBEEF; `r0_ack` one cycle later, err=0; `r1_ack` stays 0.
2. **Masked reads.** r1 reads with txn 00 while `data_out`=0x12345678 and `data_ready` is asserted 3 cycles after strobe start. Expected: `r_rdata`=0x00000078, ack 1 cycle after ready. Repeat with txn 01: `r_rdata`=0x00005678.
3. **Simultaneous requests, fresh reset.** Both requesters issue two writes each. Expected grant order 0,1,0,1; each ack goes only to its own requester.
4. **Timeout.** Read with TIMEOUT=4 and `data_ready` never asserted. Expected: strobe asserted for exactly 4 cycles, then ack with err=1 and `r_rdata`=0, then IDLE.
5. **Illegal txn and abort.** r0 issues txn=11: ack with err=1 one cycle after the IDLE sample, no strobe. Then start a read and pull `rst_n` low mid-RD: `data_read_n`=11 immediately, no ack, `busy`=0.

Source files
------------

// File: rtl/tqv_periph_bus_arbiter_if.sv
// tqv_periph_bus_arbiter_if: requester handshakes, TinyQV peripheral register bus and arbiter status.
interface tqv_periph_bus_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              r0_req, r1_req, r0_we, r1_we;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [31:0]       r0_wdata, r1_wdata;
    logic [1:0]        r0_txn, r1_txn;
    logic              r0_ack, r1_ack, r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in, data_out;
    logic [1:0]        data_write_n, data_read_n;
    logic              data_ready, busy, owner;

    modport master (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_txn,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_txn,
        input  data_out, data_ready,
        output r0_ack, r1_ack, r_err, r_rdata,
        output address, data_in, data_write_n, data_read_n, busy, owner
    );

    modport slave (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_txn,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_txn,
        output data_out, data_ready,
        input  r0_ack, r1_ack, r_err, r_rdata,
        input  address, data_in, data_write_n, data_read_n, busy, owner
    );
endinterface

// File: rtl/tqv_periph_bus_arbiter.sv
// tqv_periph_bus_arbiter: round-robin two-requester sequencer for one TinyQV peripheral,
// generating write/read strobes, masking read data by width and bounding reads with a timeout.
module tqv_periph_bus_arbiter #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    tqv_periph_bus_arbiter_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

    state_t            r_state, w_next;
    logic              r_owner, r_err_q;
    logic [1:0]        r_txn;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data_in, r_rdata_q;
    logic [7:0]        r_cnt;

    logic              w_any, w_gnt, w_we, w_timeout;
    logic [1:0]        w_txn;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata, w_rmask;

    // On a tie the requester that did not win last time gets the grant
    assign w_any     = bus.r0_req | bus.r1_req;
    assign w_gnt     = (bus.r0_req & bus.r1_req) ? ~r_owner : bus.r1_req;
    assign w_we      = w_gnt ? bus.r1_we    : bus.r0_we;
    assign w_txn     = w_gnt ? bus.r1_txn   : bus.r0_txn;
    assign w_addr    = w_gnt ? bus.r1_addr  : bus.r0_addr;
    assign w_wdata   = w_gnt ? bus.r1_wdata : bus.r0_wdata;
    assign w_timeout = r_cnt == 8'(TIMEOUT - 1);
    assign w_rmask   = r_txn == 2'b00 ? {24'b0, bus.data_out[7:0]}
                     : r_txn == 2'b01 ? {16'b0, bus.data_out[15:0]} : bus.data_out;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = w_txn == 2'b11 ? S_DONE : w_we ? S_WR : S_RD;
            S_WR:    w_next = S_DONE;
            S_RD:    if (bus.data_ready || w_timeout) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes and acks decode the state directly so reset idles them at once
    always_comb begin
        bus.data_write_n = r_state == S_WR ? r_txn : 2'b11;
        bus.data_read_n  = r_state == S_RD ? r_txn : 2'b11;
        bus.r0_ack       = r_state == S_DONE && !r_owner;
        bus.r1_ack       = r_state == S_DONE && r_owner;
        bus.busy         = r_state != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= 1'b1;
            r_txn     <= 2'b00;
            r_addr    <= '0;
            r_data_in <= 32'b0;
            r_err_q   <= 1'b0;
            r_rdata_q <= 32'b0;
            r_cnt     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_owner   <= w_gnt;
                    r_txn     <= w_txn;
                    r_addr    <= w_addr;
                    r_data_in <= w_we ? w_wdata : 32'b0;
                    r_err_q   <= w_txn == 2'b11;
                end
                S_RD: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (bus.data_ready) begin
                        r_rdata_q <= w_rmask;
                        r_err_q   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata_q <= 32'b0;
                        r_err_q   <= 1'b1;
                    end
                end
                S_DONE:  r_cnt <= 8'd0;
                default: ;
            endcase
        end
    end

    assign bus.owner   = r_owner;
    assign bus.address = r_addr;
    assign bus.data_in = r_data_in;
    assign bus.r_err   = r_err_q;
    assign bus.r_rdata = r_rdata_q;
endmodule

// File: tb/tb_tqv_periph_bus_arbiter.sv
// tb_tqv_periph_bus_arbiter: scoreboard bench; expected transactions are queued when requests
// are driven and checked against strobes and acks as the arbiter produces them.
module tb_tqv_periph_bus_arbiter;
    localparam int AW = 6;

    typedef struct {
        bit          who;
        bit          we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  txn;
        bit          err;
        logic [31:0] rdata;
        int          strobes;
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    int   n_tests = 0, n_fail = 0;
    int   rdy_at = 0, busy_n = 0, strb_n = 0, rs = 0;
    bit   stray_rdy = 0;
    exp_t sb[$];
    exp_t e;

    tqv_periph_bus_arbiter_if #(.ADDR_W(AW)) bus ();

    tqv_periph_bus_arbiter #(.ADDR_W(AW), .TIMEOUT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input bit who, input bit we, input logic [5:0] a, input logic [31:0] d,
                        input logic [1:0] t, input bit err, input logic [31:0] rd, input int strobes);
        exp_t x;
        x.who = who; x.we = we; x.addr = a; x.wdata = d; x.txn = t;
        x.err = err; x.rdata = rd; x.strobes = strobes;
        sb.push_back(x);
    endtask

    task automatic req_txn(input bit n, input bit we, input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] t);
        int k;
        bit done, scr;
        @(negedge clk);
        if (n) begin
            bus.r1_req = 1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_txn = t;
        end else begin
            bus.r0_req = 1; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_txn = t;
        end
        k = 0; done = 0; scr = 0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            done = n ? bus.r1_ack : bus.r0_ack;
            // once granted, disturb the request fields; the transfer must not notice
            if (!scr && bus.busy && bus.owner == n) begin
                scr = 1;
                if (n) begin bus.r1_addr = ~a; bus.r1_wdata = ~d; bus.r1_txn = ~t; end
                else   begin bus.r0_addr = ~a; bus.r0_wdata = ~d; bus.r0_txn = ~t; end
            end
        end
        if (!done) chk(n ? "ack_wait1" : "ack_wait0", 32'd0, 32'd1);
        if (n) bus.r1_req = 0; else bus.r0_req = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        bus.r0_req = 0; bus.r1_req = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_data_in", bus.data_in, 32'd0);
        chk("rst_rdata", bus.r_rdata, 32'd0);
        chk("rst_write_n", 32'(bus.data_write_n), 32'd3);
        chk("rst_read_n", 32'(bus.data_read_n), 32'd3);
        chk("rst_acks", 32'({bus.r1_ack, bus.r0_ack}), 32'd0);
        chk("rst_err", 32'(bus.r_err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd1);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bus.data_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || bus.data_read_n == 2'b11) begin
                rs = 0;
                bus.data_ready = stray_rdy;
            end else begin
                rs++;
                bus.data_ready = (rs == rdy_at);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy_n = 0; strb_n = 0;
        end else begin
            if (bus.busy) busy_n++;
            if (bus.data_write_n != 2'b11 || bus.data_read_n != 2'b11) begin
                strb_n++;
                if (sb.size() == 0) chk("stray_strobe", 32'({bus.data_write_n, bus.data_read_n}), 32'hF);
                else begin
                    e = sb[0];
                    chk("write_n", 32'(bus.data_write_n), 32'(e.we ? e.txn : 2'b11));
                    chk("read_n", 32'(bus.data_read_n), 32'(e.we ? 2'b11 : e.txn));
                    chk("address", 32'(bus.address), 32'(e.addr));
                    chk("data_in", bus.data_in, e.we ? e.wdata : 32'd0);
                end
            end
            if (bus.r0_ack || bus.r1_ack) begin
                if (sb.size() == 0) chk("unexp_ack", 32'({bus.r1_ack, bus.r0_ack}), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("ack_who", 32'({bus.r1_ack, bus.r0_ack}), e.who ? 32'd2 : 32'd1);
                    chk("ack_err", 32'(bus.r_err), 32'(e.err));
                    if (!e.we) chk("rdata", bus.r_rdata, e.rdata);
                    chk("strobe_cycles", 32'(strb_n), 32'(e.strobes));
                    chk("busy_cycles", 32'(busy_n), 32'(e.strobes + 1));
                end
                busy_n = 0; strb_n = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = 0; bus.r0_wdata = 0; bus.r0_txn = 0;
        bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 0; bus.r1_wdata = 0; bus.r1_txn = 0;
        bus.data_out = 32'h1234_5678;
        do_reset();

        // single write from requester 0 with a stray ready held high
        stray_rdy = 1;
        push(0, 1, 6'h05, 32'hDEAD_BEEF, 2'b10, 0, 32'd0, 1);
        req_txn(0, 1, 6'h05, 32'hDEAD_BEEF, 2'b10);
        stray_rdy = 0;

        // masked reads; ready lands on the last cycle before timeout
        rdy_at = 4;
        push(1, 0, 6'h11, 32'd0, 2'b00, 0, 32'h0000_0078, 4);
        req_txn(1, 0, 6'h11, 32'h55, 2'b00);
        push(1, 0, 6'h12, 32'd0, 2'b01, 0, 32'h0000_5678, 4);
        req_txn(1, 0, 6'h12, 32'h66, 2'b01);
        rdy_at = 1;
        bus.data_out = 32'hCAFE_F00D;
        push(0, 0, 6'h13, 32'd0, 2'b10, 0, 32'hCAFE_F00D, 1);
        req_txn(0, 0, 6'h13, 32'h77, 2'b10);

        // round robin from a fresh reset
        do_reset();
        push(0, 1, 6'h01, 32'h1111_0000, 2'b10, 0, 32'd0, 1);
        push(1, 1, 6'h31, 32'h3333_0000, 2'b00, 0, 32'd0, 1);
        push(0, 1, 6'h02, 32'h2222_0000, 2'b01, 0, 32'd0, 1);
        push(1, 1, 6'h32, 32'h4444_0000, 2'b10, 0, 32'd0, 1);
        fork
            begin
                req_txn(0, 1, 6'h01, 32'h1111_0000, 2'b10);
                req_txn(0, 1, 6'h02, 32'h2222_0000, 2'b01);
            end
            begin
                req_txn(1, 1, 6'h31, 32'h3333_0000, 2'b00);
                req_txn(1, 1, 6'h32, 32'h4444_0000, 2'b10);
            end
        join
        chk("rr_owner", 32'(bus.owner), 32'd1);

        // good read, then a timed-out read clears rdata
        rdy_at = 2;
        bus.data_out = 32'hA5A5_1234;
        push(1, 0, 6'h21, 32'd0, 2'b10, 0, 32'hA5A5_1234, 2);
        req_txn(1, 0, 6'h21, 32'd0, 2'b10);
        rdy_at = 0;
        push(0, 0, 6'h20, 32'd0, 2'b10, 1, 32'd0, 4);
        req_txn(0, 0, 6'h20, 32'd0, 2'b10);
        @(negedge clk);
        chk("timeout_idle", 32'(bus.busy), 32'd0);

        // illegal transfer width
        push(0, 1, 6'h07, 32'h1, 2'b11, 1, 32'd0, 0);
        req_txn(0, 1, 6'h07, 32'h1, 2'b11);

        // reset in the middle of a read
        push(1, 0, 6'h2A, 32'd0, 2'b01, 0, 32'd0, 0);
        @(negedge clk);
        bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 6'h2A; bus.r1_wdata = 32'h99; bus.r1_txn = 2'b01;
        k = 0;
        do begin @(negedge clk); k++; end while (bus.data_read_n == 2'b11 && k < 20);
        chk("abort_rd_strobe", 32'(bus.data_read_n), 32'd1);
        @(negedge clk);
        #2 rst_n = 0;
        sb.delete();
        #1;
        chk("abort_read_n", 32'(bus.data_read_n), 32'd3);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_acks", 32'({bus.r1_ack, bus.r0_ack}), 32'd0);
        chk("abort_owner", 32'(bus.owner), 32'd1);
        bus.r1_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("post_abort_busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
